// File: rtl/rain_drop_counter.sv
// ---------------------------------------------------------------------------
// rain_drop_counter
//
// Front end for the windshield wiper controller. A raw drop pulse from a
// switch or sensor is synchronised, debounced into single drop events, and
// the events are counted over a fixed window of clk_2 cycles. Each window's
// saturated count is published on chuva together with a one-cycle strobe.
//
// Ports:
//   clk_2        in   single clock, all state updates on its rising edge
//   reset        in   synchronous, active-high; clears every register
//   drop_in      in   raw asynchronous drop pulse, active-high
//   chuva        out  saturated drop count of the last completed window
//   chuva_valid  out  one-cycle strobe, high in the cycle chuva is updated
//   overflow     out  high while chuva reflects a window that saturated
//   window_pos   out  current cycle index within the counting window
// ---------------------------------------------------------------------------
module rain_drop_counter #(
    parameter int WINDOW_CYCLES   = 256,
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int COUNT_BITS      = 6
) (
    input  logic                             clk_2,
    input  logic                             reset,
    input  logic                             drop_in,
    output logic [COUNT_BITS-1:0]            chuva,
    output logic                             chuva_valid,
    output logic                             overflow,
    output logic [$clog2(WINDOW_CYCLES)-1:0] window_pos
);

    localparam int POS_BITS  = $clog2(WINDOW_CYCLES);
    localparam int STAB_BITS = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [POS_BITS-1:0]  LAST_POS  = POS_BITS'(WINDOW_CYCLES - 1);
    localparam logic [STAB_BITS-1:0] STAB_LAST = STAB_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [STAB_BITS-1:0] STAB_ONE  = STAB_BITS'(1);

    typedef enum logic [1:0] {
        DB_LOW,
        DB_PEND_HIGH,
        DB_HIGH,
        DB_PEND_LOW
    } dbState_t;

    logic                  sync1_q;
    logic                  sync2_q;
    dbState_t              dbState_q,    dbState_d;
    logic [STAB_BITS-1:0]  stab_q,       stab_d;
    logic [COUNT_BITS-1:0] acc_q,        acc_d;
    logic                  satFlag_q,    satFlag_d;
    logic [POS_BITS-1:0]   windowPos_q,  windowPos_d;
    logic [COUNT_BITS-1:0] chuva_q,      chuva_d;
    logic                  chuvaValid_q, chuvaValid_d;
    logic                  overflow_q,   overflow_d;

    logic                  dropEvt;
    logic                  stabDone;
    logic                  accMax;
    logic                  satHit;
    logic                  windowEnd;
    logic [COUNT_BITS-1:0] accBumped;

    // Debounce next-state logic. The drop event is decoded from the current
    // state and the sample being accepted, so it is seen by the accumulator
    // on the same edge the FSM enters HIGH. stab_q counts consecutive
    // samples that disagree with the accepted level; reaching
    // DEBOUNCE_CYCLES of them flips the level. With DEBOUNCE_CYCLES=1 the
    // pending states are skipped entirely.
    always_comb begin
        dbState_d = dbState_q;
        stab_d    = stab_q;
        dropEvt   = 1'b0;
        stabDone  = (stab_q == STAB_LAST);
        case (dbState_q)
            DB_LOW: begin
                if (sync2_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        dbState_d = DB_HIGH;
                        stab_d    = '0;
                        dropEvt   = 1'b1;
                    end else begin
                        dbState_d = DB_PEND_HIGH;
                        stab_d    = STAB_ONE;
                    end
                end
            end
            DB_PEND_HIGH: begin
                if (!sync2_q) begin
                    dbState_d = DB_LOW;
                    stab_d    = '0;
                end else if (stabDone) begin
                    dbState_d = DB_HIGH;
                    stab_d    = '0;
                    dropEvt   = 1'b1;
                end else begin
                    stab_d = stab_q + STAB_ONE;
                end
            end
            DB_HIGH: begin
                if (!sync2_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        dbState_d = DB_LOW;
                        stab_d    = '0;
                    end else begin
                        dbState_d = DB_PEND_LOW;
                        stab_d    = STAB_ONE;
                    end
                end
            end
            DB_PEND_LOW: begin
                if (sync2_q) begin
                    dbState_d = DB_HIGH;
                    stab_d    = '0;
                end else if (stabDone) begin
                    dbState_d = DB_LOW;
                    stab_d    = '0;
                end else begin
                    stab_d = stab_q + STAB_ONE;
                end
            end
            default: begin
                dbState_d = DB_LOW;
                stab_d    = '0;
            end
        endcase
    end

    // Window accumulation and publication. A drop event on the closing edge
    // is folded into the value being published rather than carried into the
    // next window. Overflow means at least one event arrived while the
    // count was already at its maximum.
    always_comb begin
        accMax       = (acc_q == {COUNT_BITS{1'b1}});
        satHit       = accMax && dropEvt;
        windowEnd    = (windowPos_q == LAST_POS);
        accBumped    = (dropEvt && !accMax) ? acc_q + COUNT_BITS'(1) : acc_q;
        chuva_d      = chuva_q;
        overflow_d   = overflow_q;
        chuvaValid_d = 1'b0;
        acc_d        = accBumped;
        satFlag_d    = satFlag_q || satHit;
        windowPos_d  = windowPos_q + POS_BITS'(1);
        if (windowEnd) begin
            chuva_d      = accBumped;
            overflow_d   = satFlag_q || satHit;
            chuvaValid_d = 1'b1;
            acc_d        = '0;
            satFlag_d    = 1'b0;
            windowPos_d  = '0;
        end
    end

    // All state lives here. Reset wins over everything, so a reset in the
    // middle of a window throws away the partial count without a strobe.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            dbState_q    <= DB_LOW;
            stab_q       <= '0;
            acc_q        <= '0;
            satFlag_q    <= 1'b0;
            windowPos_q  <= '0;
            chuva_q      <= '0;
            chuvaValid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            sync1_q      <= drop_in;
            sync2_q      <= sync1_q;
            dbState_q    <= dbState_d;
            stab_q       <= stab_d;
            acc_q        <= acc_d;
            satFlag_q    <= satFlag_d;
            windowPos_q  <= windowPos_d;
            chuva_q      <= chuva_d;
            chuvaValid_q <= chuvaValid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign chuva       = chuva_q;
    assign chuva_valid = chuvaValid_q;
    assign overflow    = overflow_q;
    assign window_pos  = windowPos_q;

endmodule

// File: tb/tb_rain_drop_counter.sv
// ---------------------------------------------------------------------------
// tb_rain_drop_counter
//
// Drives two rain_drop_counter instances from the same drop_in/reset:
//   dutA: WINDOW_CYCLES=16, DEBOUNCE_CYCLES=2, COUNT_BITS=6
//   dutB: WINDOW_CYCLES=32, DEBOUNCE_CYCLES=2, COUNT_BITS=2 (saturates early)
// A behavioural model derives expected outputs from the drop_in history:
// the level is accepted once the last DB synchronised samples agree, each
// accepted rise is one drop, and a window publishes min(drops, max) with
// overflow when drops exceeded max.
// ---------------------------------------------------------------------------
module tb_rain_drop_counter;

    localparam int WA   = 16;
    localparam int WB   = 32;
    localparam int DB   = 2;
    localparam int MAXA = 63;
    localparam int MAXB = 3;

    logic       clk_2;
    logic       reset;
    logic       drop_in;
    logic [5:0] aChuva;
    logic       aValid;
    logic       aOvf;
    logic [3:0] aPos;
    logic [1:0] bChuva;
    logic       bValid;
    logic       bOvf;
    logic [4:0] bPos;

    int total = 0;
    int bad   = 0;

    rain_drop_counter #(
        .WINDOW_CYCLES   (WA),
        .DEBOUNCE_CYCLES (DB),
        .COUNT_BITS      (6)
    ) dutA (
        .clk_2       (clk_2),
        .reset       (reset),
        .drop_in     (drop_in),
        .chuva       (aChuva),
        .chuva_valid (aValid),
        .overflow    (aOvf),
        .window_pos  (aPos)
    );

    rain_drop_counter #(
        .WINDOW_CYCLES   (WB),
        .DEBOUNCE_CYCLES (DB),
        .COUNT_BITS      (2)
    ) dutB (
        .clk_2       (clk_2),
        .reset       (reset),
        .drop_in     (drop_in),
        .chuva       (bChuva),
        .chuva_valid (bValid),
        .overflow    (bOvf),
        .window_pos  (bPos)
    );

    // Free-running clock, period 10.
    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    // Hard stop in case something wedges the stimulus.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // One comparison: counts it and reports mismatches.
    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model state.
    // ------------------------------------------------------------------
    bit   modelLive = 1'b0;
    bit   hist[$];
    bit   recent[$];
    bit   level;
    bit   s2;
    bit   allSame;
    int   evt;
    int   cntA, cntB, posA, posB, tot;
    int   expChuvaA, expOvfA, expValidA;
    int   expChuvaB, expOvfB, expValidB;

    // Model update on each rising edge. hist holds drop_in as sampled at
    // each edge since reset; the debouncer at edge k sees the sample from
    // edge k-2 (zeros right after reset).
    always @(posedge clk_2) begin
        if (reset === 1'b1) begin
            modelLive = 1'b1;
            hist.delete();
            recent.delete();
            level     = 1'b0;
            cntA      = 0;
            cntB      = 0;
            posA      = 0;
            posB      = 0;
            expChuvaA = 0;
            expOvfA   = 0;
            expValidA = 0;
            expChuvaB = 0;
            expOvfB   = 0;
            expValidB = 0;
        end else if (modelLive) begin
            s2 = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
            recent.push_back(s2);
            if (recent.size() > DB) void'(recent.pop_front());
            evt = 0;
            if (recent.size() == DB) begin
                allSame = 1'b1;
                for (int i = 1; i < DB; i++) if (recent[i] != recent[0]) allSame = 1'b0;
                if (allSame && recent[0] != level) begin
                    level = recent[0];
                    evt   = level ? 1 : 0;
                end
            end

            tot = cntA + evt;
            if (posA == WA - 1) begin
                expChuvaA = (tot > MAXA) ? MAXA : tot;
                expOvfA   = (tot > MAXA) ? 1 : 0;
                expValidA = 1;
                cntA      = 0;
            end else begin
                cntA      = tot;
                expValidA = 0;
            end
            posA = (posA + 1) % WA;

            tot = cntB + evt;
            if (posB == WB - 1) begin
                expChuvaB = (tot > MAXB) ? MAXB : tot;
                expOvfB   = (tot > MAXB) ? 1 : 0;
                expValidB = 1;
                cntB      = 0;
            end else begin
                cntB      = tot;
                expValidB = 0;
            end
            posB = (posB + 1) % WB;

            hist.push_back(drop_in);
        end
    end

    // Every falling edge once the model is live, compare both DUTs.
    always @(negedge clk_2) begin
        if (modelLive) begin
            checkOutput("A.chuva",  int'(aChuva), expChuvaA);
            checkOutput("A.valid",  int'(aValid), expValidA);
            checkOutput("A.ovf",    int'(aOvf),   expOvfA);
            checkOutput("A.pos",    int'(aPos),   posA);
            checkOutput("B.chuva",  int'(bChuva), expChuvaB);
            checkOutput("B.valid",  int'(bValid), expValidB);
            checkOutput("B.ovf",    int'(bOvf),   expOvfB);
            checkOutput("B.pos",    int'(bPos),   posB);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. All driving happens just after a falling edge.
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_2);
    endtask

    task automatic applyStimulus(input bit level, input int cycles);
        drop_in = level;
        tick(cycles);
    endtask

    task automatic doReset(input int cycles);
        reset = 1'b1;
        tick(cycles);
        reset = 1'b0;
    endtask

    task automatic pulse(input int hi, input int lo);
        applyStimulus(1'b1, hi);
        applyStimulus(1'b0, lo);
    endtask

    // Wait (bounded) for a strobe on instance 0 (A) or 1 (B); returns how
    // many cycles it took and the published values.
    task automatic waitValid(input int which, input int budget, output int waited,
                             output int c, output int o);
        bit seen;
        seen   = 1'b0;
        waited = -1;
        c      = -1;
        o      = -1;
        for (int i = 1; i <= budget && !seen; i++) begin
            @(negedge clk_2);
            if ((which == 0 && aValid === 1'b1) || (which == 1 && bValid === 1'b1)) begin
                seen   = 1'b1;
                waited = i;
                c      = (which == 0) ? int'(aChuva) : int'(bChuva);
                o      = (which == 0) ? int'(aOvf) : int'(bOvf);
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("[TB] FAIL waitValid timeout which=%0d actual=none required=strobe", which);
        end
    endtask

    int waited, c, o, nPulse, k1, k2, kb;

    initial begin
        reset   = 1'b1;
        drop_in = 1'b0;

        // Idle run: strobes at edges 16 and 32 after release, all zero.
        doReset(2);
        nPulse = 0; k1 = 0; k2 = 0; kb = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_2);
            if (aValid === 1'b1) begin
                nPulse++;
                if (nPulse == 1) k1 = k;
                if (nPulse == 2) k2 = k;
            end
            if (bValid === 1'b1 && kb == 0) kb = k;
        end
        checkOutput("t1.pulses", nPulse, 2);
        checkOutput("t1.first", k1, 16);
        checkOutput("t1.second", k2, 32);
        checkOutput("t1.bFirst", kb, 32);
        checkOutput("t1.pos40", int'(aPos), 8);
        checkOutput("t1.chuva", int'(aChuva), 0);

        // Three clean pulses from window_pos=1.
        doReset(1);
        tick(1);
        repeat (3) pulse(2, 2);
        waitValid(0, 40, waited, c, o);
        checkOutput("t2.wait", waited, 3);
        checkOutput("t2.chuva", c, 3);
        checkOutput("t2.ovf", o, 0);
        checkOutput("t2.pos", int'(aPos), 0);
        tick(1);
        checkOutput("t2.oneCycle", int'(aValid), 0);

        // Glitch ignored, dip inside a high level does not recount.
        doReset(1);
        tick(1);
        pulse(1, 3);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 3);
        waitValid(0, 40, waited, c, o);
        checkOutput("t3.chuva", c, 1);

        // Event lands on the closing edge: counted there, next window 0.
        doReset(1);
        tick(12);
        pulse(3, 0);
        drop_in = 1'b0;
        waitValid(0, 40, waited, c, o);
        checkOutput("t4.wait", waited, 1);
        checkOutput("t4.chuva", c, 1);
        waitValid(0, 40, waited, c, o);
        checkOutput("t4.nextChuva", c, 0);
        checkOutput("t4.nextOvf", o, 0);

        // Saturation on the 2-bit instance.
        doReset(1);
        tick(1);
        repeat (6) pulse(2, 2);
        waitValid(1, 40, waited, c, o);
        checkOutput("t5.chuva", c, 3);
        checkOutput("t5.ovf", o, 1);
        waitValid(1, 40, waited, c, o);
        checkOutput("t5.nextChuva", c, 0);
        checkOutput("t5.nextOvf", o, 0);

        // Reset mid-window discards two counted drops.
        doReset(1);
        tick(1);
        repeat (2) pulse(2, 2);
        doReset(1);
        checkOutput("t6.chuva", int'(aChuva), 0);
        checkOutput("t6.pos", int'(aPos), 0);
        checkOutput("t6.valid", int'(aValid), 0);
        waitValid(0, 40, waited, c, o);
        checkOutput("t6.wait", waited, 16);
        checkOutput("t6.chuva2", c, 0);

        // Random bouncing input with occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) doReset(1);
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 4)));
        end
        drop_in = 1'b0;
        tick(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
